// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter that drives the select lines of a downstream 4:1 mux.
// Latency: one cycle from sampled req to registered gnt/addr/valid; handover has no bubble.
// Backpressure: none; a requester holds req until it sees gnt, and the grant is held while req stays high.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   req    - per-source request, req[i] selects mux input in<i>
//   gnt    - one-hot grant, zero when idle
//   addr0  - mux select bit 0 (kept in idle)
//   addr1  - mux select bit 1 (kept in idle)
//   valid  - high while a grant is active
//
// Optional feature: define ARB_BURST_LIMIT_EN to force rotation after MAX_BURST
// consecutive grant cycles whenever another source is waiting.
module mux_select_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       addr0,
    output logic       addr1,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] cur;
    logic [7:0] burst_cnt;

    logic       release_gnt;
    logic [1:0] search_start;
    logic       win_found;
    logic [1:0] win_idx;

    // First set bit of r scanning start, start+1, ... modulo 4.
    // Scanning from the far end down lets the nearest hit overwrite the result.
    function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        release_gnt = (req[cur] == 1'b0);
`ifdef ARB_BURST_LIMIT_EN
        // Only rotate away when somebody else is actually waiting.
        if ((burst_cnt == BURST_LIMIT) && ((req & ~gnt) != 4'b0000)) begin
            release_gnt = 1'b1;
        end
`endif
    end

`ifndef ARB_BURST_LIMIT_EN
    logic unused_burst_limit;
    assign unused_burst_limit = ^BURST_LIMIT;
`endif

    // On release the search starts just past the releasing source, so it is
    // considered last; this is what makes the rotation fair.
    assign search_start         = (state == IDLE) ? ptr : cur + 2'd1;
    assign {win_found, win_idx} = find_winner(req, search_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cur       <= 2'd0;
            burst_cnt <= 8'd0;
            gnt       <= 4'b0000;
            addr0     <= 1'b0;
            addr1     <= 1'b0;
            valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt       <= 4'b0001 << win_idx;
                        cur       <= win_idx;
                        addr0     <= win_idx[0];
                        addr1     <= win_idx[1];
                        valid     <= 1'b1;
                        burst_cnt <= 8'd1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_gnt) begin
                        ptr <= cur + 2'd1;
                        if (win_found) begin
                            gnt       <= 4'b0001 << win_idx;
                            cur       <= win_idx;
                            addr0     <= win_idx[0];
                            addr1     <= win_idx[1];
                            burst_cnt <= 8'd1;
                        end else begin
                            // Select lines intentionally keep their last value.
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (burst_cnt != 8'hFF) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter: reset, single requester, rotation,
// wrap/fairness and asynchronous reset mid-grant.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mux_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       addr0;
    logic       addr1;
    logic       valid;

    int n_tests = 0;
    int n_fail  = 0;

    mux_select_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .addr0 (addr0),
        .addr1 (addr1),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] ea,
                             input logic ev);
        chk({tag, ".gnt"},   {4'b0000, gnt},          {4'b0000, eg});
        chk({tag, ".addr"},  {6'b0, addr1, addr0},    {6'b0, ea});
        chk({tag, ".valid"}, {7'b0, valid},           {7'b0, ev});
    endtask

    // Falling-edge reset pulse leaves ptr at 0 for the next grant.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset held with every source requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("reset", 4'b0000, 2'b00, 1'b0);
        end

        // Single requester on source 2, held for 10 cycles.
        rst_n = 1'b1;
        req   = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_out("single_hold", 4'b0100, 2'b10, 1'b1);
        end

        // Drop the request: idle, select lines keep their value.
        req = 4'b0000;
        @(negedge clk);
        check_out("single_release", 4'b0000, 2'b10, 1'b0);
        @(negedge clk);
        check_out("idle_stay", 4'b0000, 2'b10, 1'b0);

        do_reset();
        req = 4'b1111;
`ifdef ARB_BURST_LIMIT_EN
        // Forced rotation every 4 cycles, no idle cycle between grants.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] eg;
            logic [1:0] ea;
            ea = 2'((i / 4) % 4);
            eg = 4'b0001 << ea;
            @(negedge clk);
            check_out("burst_rotate", eg, ea, 1'b1);
        end
`else
        // Without a limit the first grant is held indefinitely.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_out("no_limit_hold", 4'b0001, 2'b00, 1'b1);
        end
        req = 4'b1110;
        @(negedge clk);
        check_out("no_limit_release", 4'b0010, 2'b01, 1'b1);
`endif

        // Wrap and fairness.
        req = 4'b0000;
        @(negedge clk);
        check_out("to_idle", 4'b0000, addr_now(), 1'b0);
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        check_out("wrap_src3", 4'b1000, 2'b11, 1'b1);
        req = 4'b1101;
        @(negedge clk);
        check_out("nongranted_change", 4'b1000, 2'b11, 1'b1);
        req = 4'b0101;
        @(negedge clk);
        check_out("wrap_to_0", 4'b0001, 2'b00, 1'b1);
        req = 4'b0100;
        @(negedge clk);
        check_out("fair_to_2", 4'b0100, 2'b10, 1'b1);

        // Hand over to source 3, then reset asynchronously between edges.
        req = 4'b1000;
        @(negedge clk);
        check_out("pre_async", 4'b1000, 2'b11, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_clear", 4'b0000, 2'b00, 1'b0);
        @(negedge clk);
        check_out("async_held", 4'b0000, 2'b00, 1'b0);
        req   = 4'b1010;
        rst_n = 1'b1;
        @(negedge clk);
        check_out("post_reset_grant", 4'b0010, 2'b01, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Select lines are allowed to hold any prior value in idle; this reads the
    // value the bench itself last expected before going idle.
    function automatic logic [1:0] addr_now();
`ifdef ARB_BURST_LIMIT_EN
        return 2'b00;
`else
        return 2'b01;
`endif
    endfunction

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
